rvx_sync_fifo_flagged: RTL and testbench

//  Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty

---
 rtl/rvx_sync_fifo_flagged_pkg.sv | 31 +++
 rtl/rvx_sync_fifo_flagged_if.sv | 34 +++
 rtl/rvx_fifo_mem.sv | 25 ++
 rtl/rvx_sync_fifo_flagged.sv | 120 ++++++++++++
 tb/tb_rvx_sync_fifo_flagged.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rvx_sync_fifo_flagged_pkg.sv
// Shared constants, types and pointer-compare helpers for the flagged sync FIFO.
package rvx_sync_fifo_flagged_pkg;

    // Pointer helpers take zero-extended pointers so one function serves any depth.
    localparam int PTR_ARG_W = 32;

    // Sticky error flags kept together so they reset and update as one register.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Pointers carry one extra wrap bit: equal pointers mean empty.
    function automatic logic ptr_is_empty(input logic [PTR_ARG_W-1:0] wp,
                                          input logic [PTR_ARG_W-1:0] rp,
                                          input int unsigned pw);
        logic [PTR_ARG_W-1:0] mask;
        mask = (PTR_ARG_W'(1) << pw) - PTR_ARG_W'(1);
        return ((wp ^ rp) & mask) == '0;
    endfunction

    // Only the wrap bit differs: writer is exactly one lap ahead, so full.
    function automatic logic ptr_is_full(input logic [PTR_ARG_W-1:0] wp,
                                         input logic [PTR_ARG_W-1:0] rp,
                                         input int unsigned pw);
        logic [PTR_ARG_W-1:0] mask;
        mask = (PTR_ARG_W'(1) << pw) - PTR_ARG_W'(1);
        return ((wp ^ rp) & mask) == (PTR_ARG_W'(1) << (pw - 1));
    endfunction

endpackage

// File: rtl/rvx_sync_fifo_flagged_if.sv
// Handshake, threshold and status bundle between a FIFO user (master) and the FIFO (slave).
interface rvx_sync_fifo_flagged_if #(
    parameter int BW_DATA  = 32,
    parameter int BW_COUNT = 5
) ();
    logic                flush;
    logic                wready;
    logic                wrequest;
    logic [BW_DATA-1:0]  wdata;
    logic                rready;
    logic                rrequest;
    logic [BW_DATA-1:0]  rdata;
    logic                rvalid;
    logic [BW_COUNT-1:0] count;
    logic [BW_COUNT-1:0] af_thresh;
    logic [BW_COUNT-1:0] ae_thresh;
    logic                almost_full;
    logic                almost_empty;
    logic                clear_err;
    logic                overflow;
    logic                underflow;

    modport master (
        output flush, wrequest, wdata, rrequest, af_thresh, ae_thresh, clear_err,
        input  wready, rready, rdata, rvalid, count, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  flush, wrequest, wdata, rrequest, af_thresh, ae_thresh, clear_err,
        output wready, rready, rdata, rvalid, count, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/rvx_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents not reset.
module rvx_fifo_mem #(
    parameter int BW_DATA   = 32,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [BW_DATA-1:0]   wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [BW_DATA-1:0]   rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [BW_DATA-1:0] mem [DEPTH];

    // Store the accepted write word at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rvx_sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, registered almost-full/almost-empty flags,
// optional first-word-fall-through, flush and sticky overflow/underflow flags.
module rvx_sync_fifo_flagged
    import rvx_sync_fifo_flagged_pkg::*;
#(
    parameter int BW_DATA   = 32,
    parameter int DEPTH_LOG = 4,
    parameter int FWFT      = 1,
    localparam int BW_COUNT = DEPTH_LOG + 1
) (
    input logic                   clk,
    input logic                   rst,
    rvx_sync_fifo_flagged_if.slave bus
);
    logic [BW_COUNT-1:0] wptr_reg, wptr_next;
    logic [BW_COUNT-1:0] rptr_reg, rptr_next;
    logic [BW_COUNT-1:0] count_next;
    logic                almost_full_reg, almost_empty_reg;
    fifo_err_t           err_reg, err_next;
    logic                full, empty;
    logic                wr_fire, rd_fire;
    logic                wr_accept, rd_accept;
    logic [BW_DATA-1:0]  mem_rdata;

    assign full  = ptr_is_full(PTR_ARG_W'(wptr_reg), PTR_ARG_W'(rptr_reg), BW_COUNT);
    assign empty = ptr_is_empty(PTR_ARG_W'(wptr_reg), PTR_ARG_W'(rptr_reg), BW_COUNT);

    // Acceptance uses registered state only: no pass-through when full, no bypass when empty.
    assign wr_fire   = bus.wrequest & ~full;
    assign rd_fire   = bus.rrequest & ~empty;
    assign wr_accept = wr_fire & ~bus.flush;
    assign rd_accept = rd_fire & ~bus.flush;

    // Next pointers: flush clears both, otherwise each advances on its own accepted request.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (bus.flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_fire) wptr_next = wptr_reg + BW_COUNT'(1);
            if (rd_fire) rptr_next = rptr_reg + BW_COUNT'(1);
        end
    end

    // Occupancy falls out of the pointer difference modulo 2*DEPTH.
    assign count_next = wptr_next - rptr_next;

    // Sticky errors: a new error in the same cycle as clear_err keeps the flag set.
    always_comb begin
        err_next           = err_reg;
        err_next.overflow  = (err_reg.overflow  & ~bus.clear_err) | (bus.wrequest & full);
        err_next.underflow = (err_reg.underflow & ~bus.clear_err) | (bus.rrequest & empty);
    end

    // Pointer, threshold-flag and error-flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            err_reg          <= '0;
        end else begin
            wptr_reg         <= wptr_next;
            rptr_reg         <= rptr_next;
            almost_full_reg  <= (count_next >= bus.af_thresh);
            almost_empty_reg <= (count_next <= bus.ae_thresh);
            err_reg          <= err_next;
        end
    end

    rvx_fifo_mem #(
        .BW_DATA   (BW_DATA),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr_reg[DEPTH_LOG-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr_reg[DEPTH_LOG-1:0]),
        .rdata (mem_rdata)
    );

    assign bus.wready       = ~full;
    assign bus.rready       = ~empty;
    assign bus.count        = wptr_reg - rptr_reg;
    assign bus.almost_full  = almost_full_reg;
    assign bus.almost_empty = almost_empty_reg;
    assign bus.overflow     = err_reg.overflow;
    assign bus.underflow    = err_reg.underflow;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so stale storage never leaks.
            assign bus.rdata  = empty ? '0 : mem_rdata;
            assign bus.rvalid = ~empty;
        end else begin : g_reg_read
            logic [BW_DATA-1:0] rdata_reg;
            logic               rvalid_reg;

            // Capture the head word on an accepted pop; rdata holds between pops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_accept;
                    if (rd_accept) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end

            assign bus.rdata  = rdata_reg;
            assign bus.rvalid = rvalid_reg;
        end
    endgenerate
endmodule

// File: tb/tb_rvx_sync_fifo_flagged.sv
// Drives one FWFT and one registered-read FIFO with identical stimulus and checks both
// against a queue-based model every cycle, plus literal expectations in directed phases.
module tb_rvx_sync_fifo_flagged;
    localparam int BW_DATA   = 32;
    localparam int DEPTH_LOG = 4;
    localparam int DEPTH     = 16;
    localparam int BW_COUNT  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                flush, wreq, rreq, clr;
    logic [BW_DATA-1:0]  wdata;
    logic [BW_COUNT-1:0] af_t, ae_t;

    rvx_sync_fifo_flagged_if #(.BW_DATA(BW_DATA), .BW_COUNT(BW_COUNT)) bus1 ();
    rvx_sync_fifo_flagged_if #(.BW_DATA(BW_DATA), .BW_COUNT(BW_COUNT)) bus0 ();

    assign bus1.flush = flush;  assign bus0.flush = flush;
    assign bus1.wrequest = wreq; assign bus0.wrequest = wreq;
    assign bus1.wdata = wdata;  assign bus0.wdata = wdata;
    assign bus1.rrequest = rreq; assign bus0.rrequest = rreq;
    assign bus1.af_thresh = af_t; assign bus0.af_thresh = af_t;
    assign bus1.ae_thresh = ae_t; assign bus0.ae_thresh = ae_t;
    assign bus1.clear_err = clr; assign bus0.clear_err = clr;

    rvx_sync_fifo_flagged #(.BW_DATA(BW_DATA), .DEPTH_LOG(DEPTH_LOG), .FWFT(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    rvx_sync_fifo_flagged #(.BW_DATA(BW_DATA), .DEPTH_LOG(DEPTH_LOG), .FWFT(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    // Behavioural model
    logic [BW_DATA-1:0] q[$];
    bit                 m_af, m_ae, m_ovf, m_udf, m_rv0;
    logic [BW_DATA-1:0] m_rd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_af = 1'b0; m_ae = 1'b1; m_ovf = 1'b0; m_udf = 1'b0;
        m_rv0 = 1'b0; m_rd0 = '0;
    endtask

    task automatic model_update();
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_ovf = (m_ovf && !clr) || (wreq && was_full);
        m_udf = (m_udf && !clr) || (rreq && was_empty);
        if (flush) begin
            q.delete();
            m_rv0 = 1'b0;
        end else begin
            m_rv0 = 1'b0;
            if (rreq && !was_empty) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1'b1;
            end
            if (wreq && !was_full) q.push_back(wdata);
        end
        m_af = (q.size() >= int'(af_t));
        m_ae = (q.size() <= int'(ae_t));
    endtask

    task automatic check_all();
        logic [BW_DATA-1:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        chk("count1",  32'(bus1.count),        32'(q.size()));
        chk("count0",  32'(bus0.count),        32'(q.size()));
        chk("wready",  32'(bus1.wready),       32'(q.size() < DEPTH));
        chk("rready",  32'(bus1.rready),       32'(q.size() > 0));
        chk("rready0", 32'(bus0.rready),       32'(q.size() > 0));
        chk("rdata1",  bus1.rdata,             head);
        chk("rvalid1", 32'(bus1.rvalid),       32'(q.size() > 0));
        chk("rdata0",  bus0.rdata,             m_rd0);
        chk("rvalid0", 32'(bus0.rvalid),       32'(m_rv0));
        chk("af",      32'(bus1.almost_full),  32'(m_af));
        chk("ae",      32'(bus1.almost_empty), 32'(m_ae));
        chk("af0",     32'(bus0.almost_full),  32'(m_af));
        chk("ovf",     32'(bus1.overflow),     32'(m_ovf));
        chk("udf",     32'(bus1.underflow),    32'(m_udf));
        chk("ovf0",    32'(bus0.overflow),     32'(m_ovf));
        chk("udf0",    32'(bus0.underflow),    32'(m_udf));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check_all();
        $display("cyc %0d w=%0d r=%0d fl=%0d clr=%0d wd=%0h cnt=%0d rd1=%0h rd0=%0h",
                 cyc, wreq, rreq, flush, clr, wdata, bus1.count, bus1.rdata, bus0.rdata);
    endtask

    task automatic idle();
        wreq = 1'b0; rreq = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wdata = '0;
        af_t = 5'd12;
        ae_t = 5'd3;
        model_reset();
        @(posedge clk);
        #2;
        check_all();
        chk("rst_ae_lit", 32'(bus1.almost_empty), 32'd1);
        rst = 1'b0;

        // Fill 0x00..0x0F; almost_full rises at count 12
        for (int i = 0; i < DEPTH; i++) begin
            wreq = 1'b1; wdata = 32'(i);
            step();
            chk("fill_af_lit", 32'(bus1.almost_full), 32'((i + 1) >= 12));
        end
        chk("full_wready_lit", 32'(bus1.wready), 32'd0);
        chk("full_count_lit", 32'(bus1.count), 32'd16);
        wdata = 32'h99;
        step();
        chk("ovf_lit", 32'(bus1.overflow), 32'd1);
        chk("ovf_count_lit", 32'(bus1.count), 32'd16);
        idle();

        // Drain 16; FWFT head visible before pop, registered data one cycle later
        for (int i = 0; i < DEPTH; i++) begin
            rreq = 1'b1;
            chk("drain_rd1_lit", bus1.rdata, 32'(i));
            step();
            chk("drain_rd0_lit", bus0.rdata, 32'(i));
            chk("drain_rv0_lit", 32'(bus0.rvalid), 32'd1);
            chk("drain_ae_lit", 32'(bus1.almost_empty), 32'((15 - i) <= 3));
        end
        chk("empty_rready_lit", 32'(bus1.rready), 32'd0);
        step();
        chk("udf_lit", 32'(bus1.underflow), 32'd1);
        chk("udf_rv0_lit", 32'(bus0.rvalid), 32'd0);
        idle();
        clr = 1'b1;
        step();
        idle();

        // Count 8 then simultaneous push/pop for 20 cycles across the wrap
        for (int i = 0; i < 8; i++) begin
            wreq = 1'b1; wdata = 32'h100 + 32'(i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            wreq = 1'b1; rreq = 1'b1; wdata = 32'h108 + 32'(k);
            chk("stream_rd1_lit", bus1.rdata, 32'h100 + 32'(k));
            step();
            chk("stream_cnt_lit", 32'(bus1.count), 32'd8);
        end
        idle();

        // Grow to 10 and flush with a concurrent write
        for (int i = 0; i < 2; i++) begin
            wreq = 1'b1; wdata = 32'h200 + 32'(i);
            step();
        end
        chk("pre_flush_lit", 32'(bus1.count), 32'd10);
        flush = 1'b1; wreq = 1'b1; wdata = 32'h2FF;
        step();
        idle();
        chk("flush_cnt_lit", 32'(bus1.count), 32'd0);
        chk("flush_rready_lit", 32'(bus1.rready), 32'd0);
        chk("flush_ovf_lit", 32'(bus1.overflow), 32'd0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            wreq = 1'b1; wdata = 32'h300 + 32'(i);
            step();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_cnt_lit", 32'(bus1.count), 32'd0);
        #1;
        rst = 1'b0;
        wreq = 1'b1; wdata = 32'hABC;
        step();
        chk("arst_wr_lit", bus1.rdata, 32'hABC);
        idle();
        rreq = 1'b1;
        step();
        chk("arst_rd_lit", bus0.rdata, 32'hABC);
        idle();

        // Randomized traffic with phase-dependent write/read bias
        for (int seg = 0; seg < 16; seg++) begin
            int wp, rp;
            wp = (seg % 4 == 0) ? 85 : (seg % 4 == 1) ? 15 : 50;
            rp = (seg % 4 == 0) ? 15 : (seg % 4 == 1) ? 85 : 50;
            af_t = 5'($urandom_range(0, 20));
            ae_t = 5'($urandom_range(0, 17));
            for (int c = 0; c < 80; c++) begin
                wreq  = ($urandom_range(0, 99) < wp);
                rreq  = ($urandom_range(0, 99) < rp);
                flush = ($urandom_range(0, 59) == 0);
                clr   = ($urandom_range(0, 24) == 0);
                wdata = $urandom;
                if ($urandom_range(0, 29) == 0) af_t = 5'($urandom_range(0, 20));
                if ($urandom_range(0, 29) == 0) ae_t = 5'($urandom_range(0, 17));
                step();
            end
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
